fp_div_seq: RTL
===============

FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (low = reset).
REQ-003 SHALL have port start, input, 1, request a divide; sampled only in IDLE.
REQ-004 SHALL have ports a and b, input, 32 each, IEEE-754 single dividend and divisor; captured on the edge that accepts start.
REQ-005 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-006 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-007 SHALL have port result, output, 32, IEEE-754 single quotient, registered.
REQ-008 SHALL have ports invalid, div_by_zero, overflow and underflow, output, 1 each, exception flags, registered and updated with result.

Function
REQ-009 SHALL implement FSM states IDLE, PREP, ITER and DONE.
REQ-010 IDLE with start=1 at edge k SHALL capture a and b and go to PREP; start in any other state SHALL be ignored.
REQ-011 PREP (edge k+1) SHALL classify operands and go to DONE for special cases (REQ-015), otherwise to ITER with iteration counter = 0.
REQ-012 ITER SHALL perform restoring division with 24-bit mantissas (hidden 1 restored), producing one quotient bit per edge over 24 edges (k+2..k+25), then go to DONE.
REQ-013 DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
- Normal-path done is high between edges k+25 and k+26.
- Special-path done is high between edges k+1 and k+2.
REQ-014 Mantissa alignment SHALL apply in PREP: if ma < mb, shift ma left by 1 and set adj = 1, else adj = 0; the quotient MSB is then always 1.
REQ-015 Special cases SHALL resolve in priority order; inputs with exponent 0 are treated as zero (denormals flushed).
- NaN operand, 0/0 or inf/inf gives 0x7FC00000 with invalid=1.
- x/0 gives signed inf with div_by_zero=1.
- inf/x gives signed inf.
- 0/x or x/inf gives signed zero.
REQ-016 Sign SHALL be sa XOR sb for all non-NaN results.
REQ-017 Exponent SHALL be computed as e = ea - eb + 127 - adj in a 10-bit signed intermediate.
- e >= 255 gives signed inf with overflow=1.
- e <= 0 gives signed zero with underflow=1.
REQ-018 Rounding SHALL be truncation (round toward zero); the fraction is quotient bits [22:0].
REQ-019 result and flags SHALL hold their values from DONE until the next DONE; all flags clear at the DONE that writes a new result.
REQ-020 start asserted in the same cycle as done SHALL be ignored; a new start is accepted only when the FSM is in IDLE.

Reset
REQ-021 rst low SHALL immediately force IDLE and clear busy, done, result, all flags, the counter and all datapath registers to 0.
REQ-022 rst asserted mid-operation SHALL abort the divide, produce no done pulse, and leave no residual state after release.
REQ-023 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-024 A shared package fp_pkg SHALL hold the following, shared with the multiplier pipeline:
- state encodings
- BIAS = 127
- QNAN = 0x7FC00000
- exponent and mantissa widths
REQ-025 One sub-module fp_classify SHALL decode a 32-bit operand into is_zero, is_inf and is_nan, and SHALL be instantiated once for a and once for b.
REQ-026 The datapath SHALL contain at most one 25-bit subtractor, used iteratively; no combinational divider.

Verification
REQ-027 Bench SHALL drive 0x40C00000 / 0x40000000 (6/2) -> result 0x40400000, all flags 0, done 26 cycles after start, busy high throughout.
REQ-028 Bench SHALL drive 0x3F800000 / 0x40400000 (1/3) -> result 0x3EAAAAAA (truncated), adj path exercised.
REQ-029 Bench SHALL drive 0xBF800000 / 0x00000000 -> result 0xFF800000 with div_by_zero=1, done 2 cycles after start.
REQ-030 Bench SHALL drive 0x00000000 / 0x00000000 -> 0x7FC00000 with invalid=1; 0x7F800000 / 0x7F800000 -> 0x7FC00000 with invalid=1.
REQ-031 Bench SHALL drive 0x7F000000 / 0x3E800000 -> 0x7F800000 with overflow=1; 0x00800000 / 0x4B000000 -> 0x00000000 with underflow=1.
REQ-032 Bench SHALL assert rst at iteration 10 of 6/2, then restart with 1/3 -> no done from the aborted divide, second result 0x3EAAAAAA; start pulsed while busy is ignored.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the divider and multiplier pipelines.
package fp_pkg;

  localparam int          EXP_W = 8;
  localparam int          MAN_W = 23;
  localparam int          BIAS  = 127;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Signed infinity with the given sign bit.
  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, 8'hFF, 23'h00_0000};
  endfunction

  // Signed zero with the given sign bit.
  function automatic logic [31:0] fp_zero(input logic sign);
    return {sign, 31'h0000_0000};
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Decodes one single-precision operand; exponent 0 counts as zero (denormals flushed).
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] i_op,
  output logic        o_is_zero,
  output logic        o_is_inf,
  output logic        o_is_nan
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic             w_exp_max;

  assign w_exp     = i_op[30:23];
  assign w_man     = i_op[22:0];
  assign w_exp_max = (w_exp == 8'hFF);

  assign o_is_zero = (w_exp == 8'h00);
  assign o_is_inf  = w_exp_max & (w_man == 23'h00_0000);
  assign o_is_nan  = w_exp_max & (w_man != 23'h00_0000);

endmodule

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider: one restoring-division quotient bit per clock,
// truncating rounding, denormals flushed to zero.
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  localparam logic signed [9:0] BIAS_S = 10'(BIAS);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [24:0]        r_rem;
  logic [23:0]        r_mb;
  logic [21:0]        r_q;
  logic signed [9:0]  r_exp;
  logic               r_sign;
  logic [4:0]         r_cnt;
  logic [31:0]        r_result;
  logic               r_invalid;
  logic               r_dbz;
  logic               r_ovf;
  logic               r_unf;

  logic               w_a_zero, w_a_inf, w_a_nan;
  logic               w_b_zero, w_b_inf, w_b_nan;
  logic               w_sign;
  logic [23:0]        w_ma;
  logic [23:0]        w_mb;
  logic               w_adj;
  logic [24:0]        w_rem_init;
  logic signed [9:0]  w_exp_prep;
  logic [24:0]        w_diff;
  logic               w_qbit;
  logic [24:0]        w_rem_next;
  logic               w_last;
  logic               w_special;
  logic [31:0]        w_spec_result;
  logic               w_spec_invalid;
  logic               w_spec_dbz;
  logic [31:0]        w_norm_result;
  logic               w_norm_ovf;
  logic               w_norm_unf;

  fp_classify u_cls_a (.i_op(r_a), .o_is_zero(w_a_zero), .o_is_inf(w_a_inf), .o_is_nan(w_a_nan));
  fp_classify u_cls_b (.i_op(r_b), .o_is_zero(w_b_zero), .o_is_inf(w_b_inf), .o_is_nan(w_b_nan));

  // Alignment: a smaller dividend mantissa is doubled so the quotient MSB is always 1.
  assign w_sign     = r_a[31] ^ r_b[31];
  assign w_ma       = {1'b1, r_a[22:0]};
  assign w_mb       = {1'b1, r_b[22:0]};
  assign w_adj      = (w_ma < w_mb);
  assign w_rem_init = w_adj ? {w_ma, 1'b0} : {1'b0, w_ma};
  assign w_exp_prep = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]})
                      + BIAS_S - $signed({9'd0, w_adj});

  // The only subtractor: remainder < 2*divisor, so bit 24 of the difference is the borrow.
  assign w_diff     = r_rem - {1'b0, r_mb};
  assign w_qbit     = ~w_diff[24];
  assign w_rem_next = w_qbit ? {w_diff[23:0], 1'b0} : {r_rem[23:0], 1'b0};
  assign w_last     = (r_cnt == 5'd23);

  // Special operand resolution, highest priority first.
  always_comb begin
    w_special      = 1'b1;
    w_spec_result  = QNAN;
    w_spec_invalid = 1'b0;
    w_spec_dbz     = 1'b0;
    if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
      w_spec_invalid = 1'b1;
    end else if (w_b_zero) begin
      w_spec_result = fp_inf(w_sign);
      w_spec_dbz    = 1'b1;
    end else if (w_a_inf) begin
      w_spec_result = fp_inf(w_sign);
    end else if (w_a_zero | w_b_inf) begin
      w_spec_result = fp_zero(w_sign);
    end else begin
      w_special = 1'b0;
    end
  end

  // Final packing: the quotient MSB (implicit 1) has shifted out, r_q plus the last bit is the fraction.
  always_comb begin
    w_norm_result = {r_sign, r_exp[7:0], r_q, w_qbit};
    w_norm_ovf    = 1'b0;
    w_norm_unf    = 1'b0;
    if (r_exp >= 10'sd255) begin
      w_norm_result = fp_inf(r_sign);
      w_norm_ovf    = 1'b1;
    end else if (r_exp <= 10'sd0) begin
      w_norm_result = fp_zero(r_sign);
      w_norm_unf    = 1'b1;
    end else begin
      w_norm_ovf    = 1'b0;
    end
  end

  // Next-state logic for the IDLE/PREP/ITER/DONE sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_PREP;
        else       w_state_next = S_IDLE;
      end
      S_PREP: begin
        if (w_special) w_state_next = S_DONE;
        else           w_state_next = S_ITER;
      end
      S_ITER: begin
        if (w_last) w_state_next = S_DONE;
        else        w_state_next = S_ITER;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_DONE);
    end
  end

  // Operand capture, iteration datapath and result/flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= 32'h0;
      r_b       <= 32'h0;
      r_rem     <= 25'h0;
      r_mb      <= 24'h0;
      r_q       <= 22'h0;
      r_exp     <= 10'sd0;
      r_sign    <= 1'b0;
      r_cnt     <= 5'd0;
      r_result  <= 32'h0;
      r_invalid <= 1'b0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a <= a;
            r_b <= b;
          end
        end
        S_PREP: begin
          r_cnt  <= 5'd0;
          r_q    <= 22'h0;
          r_sign <= w_sign;
          if (w_special) begin
            r_result  <= w_spec_result;
            r_invalid <= w_spec_invalid;
            r_dbz     <= w_spec_dbz;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
          end else begin
            r_rem <= w_rem_init;
            r_mb  <= w_mb;
            r_exp <= w_exp_prep;
          end
        end
        S_ITER: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[20:0], w_qbit};
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_result  <= w_norm_result;
            r_invalid <= 1'b0;
            r_dbz     <= 1'b0;
            r_ovf     <= w_norm_ovf;
            r_unf     <= w_norm_unf;
          end
        end
        S_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= 5'd0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign invalid     = r_invalid;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;
  assign underflow   = r_unf;

endmodule
